// File: rtl/traffic_pkg.sv
// Shared light and state encodings for the highway / farm-road intersection controller.
package traffic_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] light_t;

    localparam light_t GREEN  = 2'b00;
    localparam light_t YELLOW = 2'b01;
    localparam light_t RED    = 2'b10;

    localparam state_t HG = 2'd0;
    localparam state_t HY = 2'd1;
    localparam state_t FG = 2'd2;
    localparam state_t FY = 2'd3;

endpackage

// File: rtl/traffic_light_controller_if.sv
// Car-sensor input and light-head outputs of the intersection controller.
interface traffic_light_controller_if;
    import traffic_pkg::*;

    logic   C;
    light_t hl;
    light_t fl;
    state_t state;

    modport master (output C, input hl, input fl, input state);
    modport slave  (input C, output hl, output fl, output state);

endinterface

// File: rtl/interval_timer.sv
// Saturating interval counter that flags the long (green) and short (yellow) intervals.
module interval_timer #(
    parameter int unsigned TL_CYCLES = 16,
    parameter int unsigned TS_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tl,
    output logic ts
);

    localparam int unsigned CW = (TL_CYCLES > 2) ? $clog2(TL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TL_CYCLES - 1);
    localparam logic [CW-1:0] TS_MAX  = CW'(TS_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        tl = (cnt_q == CNT_MAX);
        ts = (cnt_q >= TS_MAX);
    end

endmodule

// File: rtl/traffic_light_controller.sv
// Moore controller sequencing highway green/yellow and farm green/yellow around the car sensor.
module traffic_light_controller
    import traffic_pkg::*;
#(
    parameter int unsigned TL_CYCLES = 16,
    parameter int unsigned TS_CYCLES = 4
) (
    input logic                        clk,
    input logic                        reset,
    traffic_light_controller_if.slave  bus
);

    state_t state_q;
    state_t state_d;
    logic   tl;
    logic   ts;
    logic   clear;

    interval_timer #(
        .TL_CYCLES (TL_CYCLES),
        .TS_CYCLES (TS_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .tl    (tl),
        .ts    (ts)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HG: if (tl && bus.C) state_d = HY;
            HY: if (ts) state_d = FG;
            FG: if (!bus.C || tl) state_d = FY;
            FY: if (ts) state_d = HG;
            default: state_d = HG;
        endcase
    end

    // Timer restarts on every state change so each interval is measured from entry.
    assign clear = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HG;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        bus.hl = RED;
        bus.fl = RED;
        unique case (state_q)
            HG: bus.hl = GREEN;
            HY: bus.hl = YELLOW;
            FG: bus.fl = GREEN;
            FY: bus.fl = YELLOW;
            default: begin
                bus.hl = RED;
                bus.fl = RED;
            end
        endcase
    end

    assign bus.state = state_q;

endmodule
